// File: rtl/cache_nway_pkg.sv
// Shared types and tree pseudo-LRU helpers for the N-way cache.
// Helpers operate on a 64-bit node vector so any power-of-two way count up to 64 fits.
package cache_nway_pkg;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    ALLOCATE
  } state_t;

  localparam int PLRU_MAX = 64;
  typedef logic [PLRU_MAX-1:0] plru_t;

  function automatic int plru_levels(input int ways);
    int n;
    n = 0;
    while ((1 << n) < ways) n++;
    return n;
  endfunction

  // Walk from the root: a 0 bit sends the victim search into the lower half.
  function automatic logic [5:0] plru_victim(input plru_t bits, input int ways);
    logic [5:0] node;
    logic [5:0] way;
    int lv;
    node = '0;
    way = '0;
    lv = plru_levels(ways);
    for (int l = 0; l < 6; l++) begin
      if (l < lv) begin
        way = {way[4:0], bits[node]};
        node = {node[4:0], 1'b1} + {5'b0, bits[node]};
      end
    end
    return way;
  endfunction

  function automatic plru_t plru_update(
    input plru_t bits,
    input logic [5:0] way,
    input int ways
  );
    plru_t res;
    logic [5:0] node;
    logic b;
    int lv;
    res = bits;
    node = '0;
    lv = plru_levels(ways);
    for (int l = 0; l < 6; l++) begin
      if (l < lv) begin
        b = way[3'(lv - 1 - l)];
        res[node] = ~b;
        node = {node[4:0], 1'b1} + {5'b0, b};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_nway_plru_tree.sv
// Per-set tree pseudo-LRU state: async-clear storage, access update port,
// combinational victim for the addressed set.
module plru_tree
  import cache_nway_pkg::*;
#(
  parameter int num_ways = 4,
  parameter int s_index = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [s_index-1:0]          idx,
  input  logic                        acc_en,
  input  logic [$clog2(num_ways)-1:0] acc_way,
  output logic [$clog2(num_ways)-1:0] victim
);

  localparam int nb = num_ways - 1;
  localparam int ns = 1 << s_index;
  localparam int ww = $clog2(num_ways);

  logic [nb-1:0] bits_q [ns];
  plru_t cur;
  plru_t nxt;
  logic [5:0] vic_full;

  always_comb begin
    cur = '0;
    cur[nb-1:0] = bits_q[idx];
    nxt = plru_update(cur, 6'(acc_way), num_ways);
    vic_full = plru_victim(cur, num_ways);
  end

  assign victim = vic_full[ww-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < ns; s++) bits_q[s] <= '0;
    end else if (acc_en) begin
      bits_q[idx] <= nxt[nb-1:0];
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with whole-line CPU and memory ports,
// three-state miss controller and tree pseudo-LRU replacement.
module cache_nway
  import cache_nway_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index = 3,
  parameter int num_ways = 4,
  parameter int s_tag = 32 - s_offset - s_index
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               mem_address,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [(1<<s_offset)-1:0]  mem_byte_enable256,
  input  logic [(8<<s_offset)-1:0]  mem_wdata256,
  output logic [(8<<s_offset)-1:0]  mem_rdata256,
  output logic                      mem_resp,
  output logic [31:0]               pmem_address,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [(8<<s_offset)-1:0]  pmem_wdata,
  input  logic [(8<<s_offset)-1:0]  pmem_rdata,
  input  logic                      pmem_resp
);

  localparam int lw = 8 << s_offset;
  localparam int bw = 1 << s_offset;
  localparam int ns = 1 << s_index;
  localparam int ww = $clog2(num_ways);

  logic [s_tag-1:0]   tag;
  logic [s_index-1:0] idx;

  assign tag = mem_address[31 -: s_tag];
  assign idx = mem_address[s_offset +: s_index];

  logic [lw-1:0]    data_q [num_ways][ns];
  logic [s_tag-1:0] tag_q [num_ways][ns];
  logic [ns-1:0]    valid_q [num_ways];
  logic [ns-1:0]    dirty_q [num_ways];

  state_t state, state_n;
  logic [ww-1:0] vic_q, vic_n, hit_way, inv_way, plru_vic;
  logic hit, any_inv, req;
  logic hit_ack, wr_hit, fill;

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = ww'(w);
      end
      if (!valid_q[w][idx]) begin
        any_inv = 1'b1;
        inv_way = ww'(w);
      end
    end
  end

  assign req = mem_read | mem_write;
  assign vic_n = any_inv ? inv_way : plru_vic;

  always_comb begin
    state_n = state;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = {mem_address[31:s_offset], {s_offset{1'b0}}};
    hit_ack = 1'b0;
    wr_hit = 1'b0;
    fill = 1'b0;
    unique case (state)
      CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            hit_ack = 1'b1;
            wr_hit = mem_write;
          end else if (valid_q[vic_n][idx] && dirty_q[vic_n][idx]) begin
            state_n = WRITEBACK;
          end else begin
            state_n = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tag_q[vic_q][idx], idx, {s_offset{1'b0}}};
        if (pmem_resp) state_n = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill = 1'b1;
          state_n = CHECK;
        end
      end
      default: state_n = CHECK;
    endcase
  end

  assign pmem_wdata = data_q[vic_q][idx];
  assign mem_rdata256 = data_q[hit_way][idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CHECK;
      vic_q <= '0;
    end else begin
      state <= state_n;
      if (state == CHECK && state_n != CHECK) vic_q <= vic_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < num_ways; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else if (fill) begin
      valid_q[vic_q][idx] <= 1'b1;
      dirty_q[vic_q][idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[hit_way][idx] <= 1'b1;
    end
  end

  // Contents need no reset; fill is gated off by the async-reset state.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[vic_q][idx] <= pmem_rdata;
      tag_q[vic_q][idx] <= tag;
    end else if (wr_hit) begin
      for (int b = 0; b < bw; b++) begin
        if (mem_byte_enable256[b])
          data_q[hit_way][idx][8*b +: 8] <= mem_wdata256[8*b +: 8];
      end
    end
  end

  plru_tree #(
    .num_ways(num_ways),
    .s_index(s_index)
  ) u_plru (
    .clk(clk),
    .rst(rst),
    .idx(idx),
    .acc_en(hit_ack),
    .acc_way(hit_way),
    .victim(plru_vic)
  );

endmodule
